// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes, FSM states and the control bundle for the pipelined control unit.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SINN = 4'b0011;
    localparam logic [3:0] OP_MAC  = 4'b0100;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b1011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_MUL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MULTI,
        ST_DRAIN,
        ST_HALTED
    } ctrl_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu1;
        logic [2:0] alu2;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b1,
        mem_write:  1'b0,
        alu1:       ALU_PASS,
        alu2:       ALU_PASS,
        alu_src:    1'b0,
        reg_dst:    1'b0
    };

    function automatic ctrl_bundle_t mk_ctrl(input logic rw, input logic m2r, input logic mw,
                                             input logic [2:0] a1, input logic [2:0] a2,
                                             input logic src, input logic dst);
        ctrl_bundle_t c;
        c.reg_write  = rw;
        c.mem_to_reg = m2r;
        c.mem_write  = mw;
        c.alu1       = a1;
        c.alu2       = a2;
        c.alu_src    = src;
        c.reg_dst    = dst;
        return c;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode into the control bundle plus MAC/HALT/illegal classification.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                is_mac_o,
    output logic                is_halt_o,
    output logic                illegal_o
);

    logic         high_set;
    logic [3:0]   op4;
    ctrl_bundle_t ctrl_b;

    // Any bit above the 4 decoded bits makes the encoding illegal.
    assign high_set = (opcode_i >> 4) != '0;
    assign op4      = opcode_i[3:0];

    always_comb begin
        ctrl_b    = CTRL_BUBBLE;
        is_mac_o  = 1'b0;
        is_halt_o = 1'b0;
        illegal_o = 1'b0;
        if (high_set) begin
            illegal_o = 1'b1;
        end else begin
            case (op4)
                OP_NOP:  ctrl_b = CTRL_BUBBLE;
                OP_ADD:  ctrl_b = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_ADD, ALU_PASS, 1'b0, 1'b1);
                OP_ADDI: ctrl_b = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_ADD, ALU_PASS, 1'b1, 1'b0);
                OP_MUL:  ctrl_b = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_MUL, ALU_PASS, 1'b0, 1'b1);
                OP_SINN: ctrl_b = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_SLT, ALU_PASS, 1'b0, 1'b1);
                OP_MAC: begin
                    ctrl_b   = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_MUL, ALU_ADD, 1'b0, 1'b1);
                    is_mac_o = 1'b1;
                end
                OP_LD:   ctrl_b = mk_ctrl(1'b1, 1'b0, 1'b0, ALU_ADD, ALU_PASS, 1'b1, 1'b0);
                OP_ST:   ctrl_b = mk_ctrl(1'b0, 1'b0, 1'b1, ALU_ADD, ALU_PASS, 1'b1, 1'b0);
                OP_HALT: is_halt_o = 1'b1;
                default: illegal_o = 1'b1;
            endcase
        end
    end

    assign ctrl_o = ctrl_b;

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered control unit: decode, multi-cycle MAC sequencing, HALT drain FSM, sticky illegal flag.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ALU_CTRL_W   = 3,
    parameter int MAC_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  opcode_valid,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  stall_in,
    output logic                  pc_en,
    output logic                  ctrl_valid,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_write,
    output logic [ALU_CTRL_W-1:0] alu_control1,
    output logic [ALU_CTRL_W-1:0] alu_control2,
    output logic                  alu_src,
    output logic                  reg_dst,
    output logic                  halted,
    output logic                  illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           retired_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [3:0] MAC_LAST   = 4'(MAC_CYCLES - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic       MAC_MULTI  = (MAC_CYCLES > 1);

    ctrl_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    ctrl_bundle_t      ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;

    logic [CTRL_W-1:0] dec_bits;
    ctrl_bundle_t      dec_ctrl;
    logic              dec_mac, dec_halt, dec_illegal;
    logic              accept;

    opcode_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode_i  (opcode),
        .ctrl_o    (dec_bits),
        .is_mac_o  (dec_mac),
        .is_halt_o (dec_halt),
        .illegal_o (dec_illegal)
    );

    assign dec_ctrl = ctrl_bundle_t'(dec_bits);
    assign accept   = (state_q == ST_RUN) && opcode_valid && !stall_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = CTRL_BUBBLE;
        valid_d   = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else if (dec_halt) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else if (dec_mac && MAC_MULTI) begin
                        ctrl_d  = dec_ctrl;
                        state_d = ST_MULTI;
                        cnt_d   = MAC_LAST;
                    end else begin
                        ctrl_d  = dec_ctrl;
                        valid_d = 1'b1;
                    end
                end
            end
            // MAC controls stay on the ALUs; only the final cycle retires.
            ST_MULTI: begin
                ctrl_d = ctrl_q;
                if (cnt_q == 4'd1) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_en        = (state_q == ST_RUN) && !stall_in;
    assign ctrl_valid   = valid_q;
    assign reg_write    = ctrl_q.reg_write;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign mem_write    = ctrl_q.mem_write;
    assign alu_control1 = ALU_CTRL_W'(ctrl_q.alu1);
    assign alu_control2 = ALU_CTRL_W'(ctrl_q.alu2);
    assign alu_src      = ctrl_q.alu_src;
    assign reg_dst      = ctrl_q.reg_dst;
    assign halted       = (state_q == ST_HALTED);
    assign illegal_op   = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (valid_q) begin
                retired_q <= retired_q + 32'd1;
            end
            if ((state_q == ST_RUN) && stall_in) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed plus randomized bench against a cycle-scheduling reference model of the control unit.
module tb_pipelined_control_unit;

    localparam int MACC = 3;
    localparam int DRC  = 3;
    localparam logic [12:0] BUB = 13'b0_1_0_111_111_0_0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       opcode_valid = 1'b0;
    logic [3:0] opcode = 4'b0000;
    logic       stall_in = 1'b0;
    logic       pc_en, ctrl_valid, reg_write, mem_to_reg, mem_write;
    logic [2:0] alu_control1, alu_control2;
    logic       alu_src, reg_dst, halted, illegal_op;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: a queue of output words scheduled for upcoming cycles.
    logic [13:0] sched[$];
    logic [13:0] cur;
    int          blocked;
    bit          stopped;
    int          halt_in;
    bit          ill_m;
    logic [31:0] ret_m, stl_m;

    pipelined_control_unit #(
        .OPCODE_W     (4),
        .ALU_CTRL_W   (3),
        .MAC_CYCLES   (MACC),
        .DRAIN_CYCLES (DRC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .stall_in     (stall_in),
        .pc_en        (pc_en),
        .ctrl_valid   (ctrl_valid),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .mem_write    (mem_write),
        .alu_control1 (alu_control1),
        .alu_control2 (alu_control2),
        .alu_src      (alu_src),
        .reg_dst      (reg_dst),
        .halted       (halted),
        .illegal_op   (illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'b0000: return 13'b0_1_0_111_111_0_0;
            4'b0001: return 13'b1_1_0_000_111_0_1;
            4'b1001: return 13'b1_1_0_000_111_1_0;
            4'b0010: return 13'b1_1_0_001_111_0_1;
            4'b0011: return 13'b1_1_0_010_111_0_1;
            4'b0100: return 13'b1_1_0_001_000_0_1;
            4'b1110: return 13'b1_0_0_000_111_1_0;
            4'b1111: return 13'b0_0_1_000_111_1_0;
            default: return BUB;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b1110, 4'b1111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        blocked = 0;
        stopped = 0;
        halt_in = 0;
        ill_m   = 0;
        ret_m   = '0;
        stl_m   = '0;
        cur     = {1'b0, BUB};
    endtask

    task automatic step(input logic rn, input logic v, input logic [3:0] op, input logic st);
        bit run, acc;
        @(negedge clk);
        rst_n = rn; opcode_valid = v; opcode = op; stall_in = st;
        #1;
        run = !stopped && (blocked == 0);
        chk("pc_en", {31'd0, pc_en}, {31'd0, run && !st});
        acc = rn && run && v && !st;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            if (run && st) stl_m++;
            if (cur[13]) ret_m++;
            if (blocked > 0) blocked--;
            if (halt_in > 0) halt_in--;
            if (acc) begin
                if (op == 4'b1011) begin
                    stopped = 1;
                    halt_in = DRC + 1;
                end else if (!is_legal(op)) begin
                    ill_m = 1;
                end else if (op == 4'b0100) begin
                    for (int i = 1; i <= MACC; i++) sched.push_back({(i == MACC), ref_ctrl(op)});
                    blocked = MACC - 1;
                end else begin
                    sched.push_back({1'b1, ref_ctrl(op)});
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = {1'b0, BUB};
        end
        #1;
        chk("ctrl_valid", {31'd0, ctrl_valid}, {31'd0, cur[13]});
        chk("ctrl_bundle", {19'd0, reg_write, mem_to_reg, mem_write, alu_control1, alu_control2, alu_src, reg_dst},
            {19'd0, cur[12:0]});
        chk("halted", {31'd0, halted}, {31'd0, stopped && (halt_in == 0)});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, ill_m});
`ifdef CTRL_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, ret_m);
        chk("stall_cnt", stall_cnt, stl_m);
`endif
    endtask

    initial begin
        bit rn, v, st;
        logic [3:0] op;
        model_reset();

        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        chk("reset_valid", {31'd0, ctrl_valid}, 32'd0);

        step(1, 1, 4'b0001, 0);
        chk("add_alu1", {29'd0, alu_control1}, 32'd0);
        chk("add_regdst", {31'd0, reg_dst}, 32'd1);

        step(1, 1, 4'b0100, 0);
        chk("mac_alu2", {29'd0, alu_control2}, 32'd0);
        step(1, 1, 4'b0001, 1);
        step(1, 1, 4'b0010, 0);
        chk("mac_last_valid", {31'd0, ctrl_valid}, 32'd1);
        step(1, 0, 4'b0000, 0);

        step(1, 1, 4'b1110, 1);
        step(1, 1, 4'b1110, 1);
        step(1, 1, 4'b1110, 0);
        chk("ld_m2r", {31'd0, mem_to_reg}, 32'd0);
        step(1, 0, 4'b0000, 0);

        step(1, 1, 4'b0101, 0);
        chk("illegal_set", {31'd0, illegal_op}, 32'd1);
        step(1, 1, 4'b1111, 0);
        chk("st_memwrite", {31'd0, mem_write}, 32'd1);

        step(1, 1, 4'b0100, 0);
        step(0, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);

        step(0, 0, 4'b0000, 0);
        step(1, 1, 4'b0001, 0);
        step(1, 1, 4'b0010, 0);
        step(1, 1, 4'b0011, 1);
        step(1, 1, 4'b0011, 1);

        step(1, 1, 4'b1011, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 4'b0001, 0);
        chk("halt_final", {31'd0, halted}, 32'd1);
        step(0, 0, 4'b0000, 0);

        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 80) != 0);
            if (stopped && halt_in == 0 && $urandom_range(0, 5) == 0) rn = 0;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1011 && $urandom_range(0, 4) != 0) op = 4'b0100;
            step(rn, v, op, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered, multi-cycle successor to the single-cycle opcode decoder.
- Decodes a 4-bit opcode into datapath controls one cycle after acceptance.
- Adds:
  - parametrised multi-cycle MAC sequencing with PC stall;
  - external hazard stall;
  - HALT drain-then-stop FSM, replacing simulation $finish;
  - sticky illegal-opcode flag.
- Sits between the instruction fetch register and the ALU/regfile/data-memory datapath.

Parameters:
- OPCODE_W, 4, opcode width. Only the low 4 bits are decoded; any higher set bit makes the opcode illegal.
- ALU_CTRL_W, 3, width of each ALU control field.
- MAC_CYCLES, 2, cycles a MAC occupies the ALUs, range 1..15. With 1, MAC behaves like a single-cycle op.
- DRAIN_CYCLES, 3, cycles waited after HALT before asserting halted, range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode_valid  in  1  opcode is valid this cycle.
- opcode  in  OPCODE_W  instruction opcode.
- stall_in  in  1  hazard stall from datapath.
- pc_en  out  1  PC enable; combinational from state and stall_in.
- ctrl_valid  out  1  registered controls describe a real instruction this cycle.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  1 selects ALU2 result, 0 selects memory data.
- mem_write  out  1  data memory write enable.
- alu_control1  out  ALU_CTRL_W  ALU1 op.
- alu_control2  out  ALU_CTRL_W  ALU2 op.
- alu_src  out  1  1 selects immediate.
- reg_dst  out  1  1 selects Rd, 0 selects Rt.
- halted  out  1  core stopped.
- illegal_op  out  1  sticky illegal-opcode flag.

Behaviour:
- Decode table (reg_write, mem_to_reg, mem_write, alu1, alu2, alu_src, reg_dst):
  - NOP 0000: 0,1,0,111,111,0,0
  - ADD 0001: 1,1,0,000,111,0,1
  - ADDI 1001: 1,1,0,000,111,1,0
  - MUL 0010: 1,1,0,001,111,0,1
  - SINN 0011: 1,1,0,010,111,0,1
  - MAC 0100: 1,1,0,001,000,0,1
  - LD 1110: 1,1→0 (mem_to_reg=0),0,000,111,1,0
  - ST 1111: 0,0,1,000,111,1,0
  - HALT 1011: special, see DRAIN.
  - All other encodings are illegal.
- Bubble = NOP control values with ctrl_valid=0.
- Reset (rst_n=0 at a rising edge):
  - state=RUN, all counters 0;
  - all control outputs take bubble values; ctrl_valid=0, halted=0, illegal_op=0.
  - Reset mid-MAC or mid-DRAIN aborts the operation immediately.
- States: RUN, MULTI, DRAIN, HALTED.
- pc_en:
  - RUN: pc_en = !stall_in.
  - MULTI, DRAIN, HALTED: pc_en = 0.
- Accept condition: state==RUN && opcode_valid && !stall_in. Latency: controls are registered at the accept edge and visible the next cycle.
- RUN, on accept:
  - legal non-MAC, non-HALT opcode: load its controls, ctrl_valid=1, stay in RUN.
  - MAC with MAC_CYCLES>1: load MAC controls, ctrl_valid=0, counter=MAC_CYCLES-1, go to MULTI.
  - MAC with MAC_CYCLES=1: same as any single-cycle op.
  - HALT: load bubble, counter=DRAIN_CYCLES, go to DRAIN.
  - illegal opcode: set illegal_op (cleared only by reset), load bubble, stay in RUN.
  - NOP: load NOP controls with ctrl_valid=1 (a retired NOP).
- RUN, no accept (stall_in=1 or opcode_valid=0): load bubble.
- MULTI:
  - MAC controls held stable; counter decrements each cycle.
  - stall_in and opcode are ignored.
  - When counter reaches 1: assert ctrl_valid=1 for that final cycle, then return to RUN.
  - Net effect: MAC controls are visible for MAC_CYCLES cycles, with ctrl_valid only on the last one.
- DRAIN:
  - Outputs bubble; counter decrements.
  - When counter reaches 0: go to HALTED.
- HALTED:
  - halted=1, bubble outputs, pc_en=0.
  - Absorbing state; only reset exits.
- Simultaneous events: stall_in high in the same cycle as a valid opcode means no accept; the opcode must be re-presented.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt[31:0], incremented on every cycle with ctrl_valid=1.
  - Adds stall_cnt[31:0], incremented every RUN cycle with stall_in=1.
  - Both counters reset to 0 and wrap modulo 2^32.
  - Both keep their value in HALTED.
- Undefined: neither port exists; no counter logic is generated.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams: OP_NOP, OP_ADD, OP_ADDI, OP_MUL, OP_SINN, OP_MAC, OP_LD, OP_ST, OP_HALT;
  - ALU codes: ALU_ADD=000, ALU_MUL=001, ALU_SLT=010, ALU_PASS=111;
  - state enum ctrl_state_t;
  - packed struct ctrl_bundle_t covering the seven control fields;
  - constant CTRL_BUBBLE.
- One sub-module, opcode_decoder: purely combinational, maps opcode to {ctrl_bundle_t, is_mac, is_halt, illegal}.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Reset, then ADD(0001) accepted at cycle 1 → cycle 2 shows reg_write=1, alu1=000, alu2=111, reg_dst=1, ctrl_valid=1.
- MAC(0100) with MAC_CYCLES=3 →
  - pc_en=0 for 2 cycles after accept;
  - MAC controls (alu1=001, alu2=000) stable for 3 cycles;
  - ctrl_valid=1 only on the third;
  - pc_en=1 again in the following cycle.
- LD(1110) presented with stall_in=1 for 2 cycles, then 0 → pc_en=0 and bubble for 2 cycles; mem_to_reg=0, alu_src=1 one cycle after the stall drops.
- Opcode 0101 → illegal_op=1 the next cycle and stays 1 through a subsequent ST(1111), which produces mem_write=1.
- HALT(1011) with DRAIN_CYCLES=3 → halted=1 exactly 4 cycles after accept; pc_en=0 thereafter; later opcodes ignored.
- rst_n=0 during MULTI → next cycle shows bubble, state RUN, pc_en=1 (stall_in=0).
- With CTRL_PERF_CNT_EN: ADD, MUL, 2 stall cycles → retired_cnt=2, stall_cnt=2.
